// File: rtl/conv_pkg.sv
// Types and default sizes shared by the convolution datapath blocks.
package conv_pkg;

  localparam int unsigned MUL_W   = 16;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned PE_ROWS = 4;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} acc_state_e;

endpackage

// File: rtl/pe_col_adder_tree.sv
// Combinational sum of the NUM_PE product lanes of one PE column.
module pe_col_adder_tree #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned MUL_W  = 16,
  parameter int unsigned SUM_W  = MUL_W + $clog2(NUM_PE)
) (
  input  logic [NUM_PE*MUL_W-1:0] i_prod,
  output logic [SUM_W-1:0]        o_sum
);

  // Sum is wide enough that it cannot overflow for NUM_PE full-scale lanes
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      o_sum = o_sum + SUM_W'(i_prod[i*MUL_W +: MUL_W]);
    end
  end

endmodule

// File: rtl/pe_col_accumulator.sv
// Sums one PE column per beat and accumulates acc_len beats into a psum on a valid/ready port.
module pe_col_accumulator #(
  parameter int unsigned NUM_PE = conv_pkg::PE_ROWS,
  parameter int unsigned MUL_W  = conv_pkg::MUL_W,
  parameter int unsigned ACC_W  = conv_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0]             acc_len,
  input  logic                    prod_valid,
  input  logic [NUM_PE*MUL_W-1:0] prod_in,
  output logic                    in_ready,
  output logic                    psum_valid,
  input  logic                    psum_ready,
  output logic [ACC_W-1:0]        psum_out,
  output logic                    busy,
  output logic                    done
);

  import conv_pkg::*;

  localparam int unsigned SUM_W = MUL_W + $clog2(NUM_PE);

  acc_state_e         r_state;
  acc_state_e         w_state_next;
  logic [15:0]        r_len;
  logic [15:0]        r_cnt;
  logic [SUM_W-1:0]   r_col_sum;
  logic               r_col_v;
  logic [ACC_W-1:0]   r_acc;
  logic [SUM_W-1:0]   w_tree_sum;
  logic               w_accept;
  logic               w_last;
  logic               w_arm;

  pe_col_adder_tree #(
    .NUM_PE (NUM_PE),
    .MUL_W  (MUL_W),
    .SUM_W  (SUM_W)
  ) u_adder_tree (
    .i_prod (prod_in),
    .o_sum  (w_tree_sum)
  );

  assign w_accept = (r_state == ACC) && prod_valid;
  assign w_last   = w_accept && (r_cnt == r_len - 16'd1);
  assign w_arm    = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = (acc_len != 16'd0) ? ACC : OUT;
      ACC:     if (w_last) w_state_next = DRAIN;
      DRAIN:   w_state_next = OUT;
      OUT:     if (psum_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    psum_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      IDLE:    busy = 1'b0;
      ACC:     in_ready = 1'b1;
      DRAIN:   ;
      OUT: begin
        psum_valid = 1'b1;
        done       = psum_ready;
      end
      default: ;
    endcase
  end

  // Two-stage datapath: column sum is registered, then folded into the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_col_sum <= '0;
      r_col_v   <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_col_v <= w_accept;
      if (w_accept) begin
        r_col_sum <= w_tree_sum;
      end
      if (w_arm) begin
        r_len <= acc_len;
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + 16'd1;
        end
        if (r_col_v) begin
          r_acc <= r_acc + ACC_W'(r_col_sum);
        end
      end
    end
  end

  assign psum_out = r_acc;

endmodule

// File: tb/tb_pe_col_accumulator.sv
// Directed bench for pe_col_accumulator: job table plus hand-written reset-abort sequence.
module tb_pe_col_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] acc_len = '0;
  logic        prod_valid = 1'b0;
  logic [63:0] prod_in = '0;
  logic        psum_ready = 1'b0;
  logic        in_ready, psum_valid, busy, done;
  logic [31:0] psum_out;
  logic        in_ready16, psum_valid16, busy16, done16;
  logic [15:0] psum_out16;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string           name;
    logic [15:0]     len;
    logic [3:0][63:0] beats;
    bit              gaps;
    int              hold;
    bit              start_in_hold;
    bit              ready_early;
    logic [31:0]     exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  pe_col_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .acc_len    (acc_len),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .in_ready   (in_ready),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_out   (psum_out),
    .busy       (busy),
    .done       (done)
  );

  pe_col_accumulator #(
    .ACC_W (16)
  ) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .acc_len    (acc_len),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .in_ready   (in_ready16),
    .psum_valid (psum_valid16),
    .psum_ready (psum_ready),
    .psum_out   (psum_out16),
    .busy       (busy16),
    .done       (done16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_psum_valid"}, 32'(psum_valid), 32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    int   k;
    int   cyc;
    v = vecs[idx];
    @(posedge clk); #1;
    start      = 1'b1;
    acc_len    = v.len;
    prod_valid = 1'b0;
    psum_ready = 1'b0;
    @(posedge clk); #1;
    start   = 1'b0;
    acc_len = 16'hBEEF;
    if (v.len != 16'd0) begin
      k   = 0;
      cyc = 0;
      while (k < int'(v.len) && cyc < 64) begin
        if (v.gaps && (cyc % 2 == 1)) begin
          prod_valid = 1'b0;
          prod_in    = 64'hAAAA_AAAA_AAAA_AAAA;
        end else begin
          prod_valid = 1'b1;
          prod_in    = v.beats[k];
        end
        psum_ready = v.ready_early;
        #1;
        check({v.name, "_acc_in_ready"}, 32'(in_ready), 32'd1);
        check({v.name, "_acc_done"},     32'(done),     32'd0);
        check({v.name, "_acc_pvalid"},   32'(psum_valid), 32'd0);
        @(posedge clk); #1;
        if (prod_valid) k++;
        cyc++;
      end
      check({v.name, "_beats_taken"}, 32'(k), 32'(v.len));
      prod_valid = 1'b0;
      psum_ready = 1'b0;
      #1;
      check({v.name, "_drain_in_ready"}, 32'(in_ready),   32'd0);
      check({v.name, "_drain_pvalid"},   32'(psum_valid), 32'd0);
      check({v.name, "_drain_busy"},     32'(busy),       32'd1);
      @(posedge clk); #1;
    end
    check({v.name, "_psum_valid"}, 32'(psum_valid), 32'd1);
    check({v.name, "_psum_out"},   psum_out,        v.exp);
    check({v.name, "_psum_out16"}, 32'(psum_out16), {16'd0, v.exp[15:0]});
    check({v.name, "_out_in_ready"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      psum_ready = 1'b0;
      start      = v.start_in_hold;
      acc_len    = 16'd7;
      #1;
      check({v.name, "_hold_pvalid"}, 32'(psum_valid), 32'd1);
      check({v.name, "_hold_psum"},   psum_out,        v.exp);
      check({v.name, "_hold_done"},   32'(done),       32'd0);
      @(posedge clk); #1;
    end
    start      = 1'b0;
    psum_ready = 1'b1;
    #1;
    check({v.name, "_done_pulse"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    psum_ready = 1'b0;
    #1;
    check_idle({v.name, "_after"});
  endtask

  initial begin
    vecs[0] = '{name: "len3_b2b", len: 16'd3,
                beats: {64'd0, 64'hFE01_FE01_FE01_FE01, 64'h000A_000A_000A_000A,
                        64'h0004_0003_0002_0001},
                gaps: 1'b0, hold: 0, start_in_hold: 1'b0, ready_early: 1'b0,
                exp: 32'd260150};
    vecs[1] = '{name: "len4_gaps", len: 16'd4,
                beats: {4{64'h0005_0005_0005_0005}},
                gaps: 1'b1, hold: 0, start_in_hold: 1'b0, ready_early: 1'b0, exp: 32'd80};
    vecs[2] = '{name: "len0", len: 16'd0, beats: '0,
                gaps: 1'b0, hold: 0, start_in_hold: 1'b0, ready_early: 1'b0, exp: 32'd0};
    vecs[3] = '{name: "hold5", len: 16'd2,
                beats: {64'd0, 64'd0, 64'h0000_0000_0000_0064, 64'h0004_0003_0002_0001},
                gaps: 1'b0, hold: 5, start_in_hold: 1'b1, ready_early: 1'b1, exp: 32'd110};
    vecs[4] = '{name: "wrap16", len: 16'd2,
                beats: {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                gaps: 1'b0, hold: 0, start_in_hold: 1'b0, ready_early: 1'b0,
                exp: 32'h0007_FFF8};
    vecs[5] = '{name: "post_reset", len: 16'd1,
                beats: {64'd0, 64'd0, 64'd0, 64'h0001_0001_0001_0001},
                gaps: 1'b0, hold: 0, start_in_hold: 1'b0, ready_early: 1'b0, exp: 32'd4};

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_psum_out", psum_out, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_job(i);

    // Abort a 4-beat job after two accepted beats
    @(posedge clk); #1;
    start   = 1'b1;
    acc_len = 16'd4;
    @(posedge clk); #1;
    start      = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 64'h0009_0009_0009_0009;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort_psum_out",   psum_out,        32'd0);
    check("abort_psum_out16", 32'(psum_out16), 32'd0);
    prod_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    run_job(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation timed out");
  end

endmodule
